snoop_request_arbiter: RTL

// - Sits upstream of the snoop controller and serialises snoop traffic from N_PE private caches.
// - Each PE posts either a read-miss lookup (REQ) or a write-update broadcast (NEW_DATA).
// - The block buffers one request per PE and grants round-robin, one transaction at a time.
// - It drives a single address/data/strobe channel into the controller and returns completion to the requester.

---
 rtl/snoop_request_arbiter_pkg.sv | 29 ++
 rtl/snoop_request_arbiter_if.sv | 38 +++
 rtl/snoop_request_arbiter_rr_arbiter.sv | 40 ++++
 rtl/snoop_request_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/snoop_request_arbiter_pkg.sv
// Shared widths, request encodings, FSM state codes and slot layout for the
// snoop request arbiter.
package snoop_request_arbiter_pkg;

  localparam int SNOOP_ADDR_W  = 28;
  localparam int SNOOP_BLOCK_W = 128;
  localparam int SNOOP_IDX_W   = 4;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_STROBE     = 3'd2;
  localparam logic [2:0] ST_WAIT_BCAST = 3'd3;
  localparam logic [2:0] ST_WAIT_RESP  = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  typedef struct packed {
    logic                     req_type;
    logic [SNOOP_ADDR_W-1:0]  addr;
    logic [SNOOP_BLOCK_W-1:0] data;
  } slot_t;

  function automatic logic is_write(input logic req_type);
    return req_type == REQ_WRITE;
  endfunction

endpackage

// File: rtl/snoop_request_arbiter_if.sv
// PE request/response and snoop-controller channel bundle. The arbiter
// uses the slave modport; PE caches and the controller sit on master.
interface snoop_request_arbiter_if #(
  parameter int N_PE = 2
);
  import snoop_request_arbiter_pkg::*;

  logic [N_PE-1:0]               pe_req_valid;
  logic [N_PE-1:0]               pe_req_ready;
  logic [N_PE-1:0]               pe_req_type;
  logic [N_PE*SNOOP_ADDR_W-1:0]  pe_req_addr;
  logic [N_PE*SNOOP_BLOCK_W-1:0] pe_req_data;
  logic [N_PE-1:0]               pe_resp_valid;
  logic                          pe_resp_found;
  logic [SNOOP_ADDR_W-1:0]       sc_addr;
  logic [SNOOP_BLOCK_W-1:0]      sc_data;
  logic [SNOOP_IDX_W-1:0]        sc_pe_idx;
  logic                          sc_new_data;
  logic                          sc_request;
  logic                          sc_data_found;
  logic                          sc_data_not_found;
  logic                          timeout_err;

  modport master (
    output pe_req_valid, pe_req_type, pe_req_addr, pe_req_data,
    output sc_data_found, sc_data_not_found,
    input  pe_req_ready, pe_resp_valid, pe_resp_found,
    input  sc_addr, sc_data, sc_pe_idx, sc_new_data, sc_request, timeout_err
  );

  modport slave (
    input  pe_req_valid, pe_req_type, pe_req_addr, pe_req_data,
    input  sc_data_found, sc_data_not_found,
    output pe_req_ready, pe_resp_valid, pe_resp_found,
    output sc_addr, sc_data, sc_pe_idx, sc_new_data, sc_request, timeout_err
  );

endinterface

// File: rtl/snoop_request_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first request strictly after ptr, wrapping
// around; returns a one-hot grant and its binary index.
module rr_arbiter
  import snoop_request_arbiter_pkg::*;
#(
  parameter int N_PE = 2
) (
  input  logic [N_PE-1:0]        req,
  input  logic [SNOOP_IDX_W-1:0] ptr,
  output logic [N_PE-1:0]        gnt,
  output logic [SNOOP_IDX_W-1:0] gnt_idx,
  output logic                   gnt_valid
);

  logic                   hi_hit_s;
  logic                   lo_hit_s;
  logic [SNOOP_IDX_W-1:0] hi_idx_s;
  logic [SNOOP_IDX_W-1:0] lo_idx_s;

  // Descending scan so the lowest index above / at-or-below ptr is kept last
  always_comb begin
    hi_hit_s = 1'b0;
    lo_hit_s = 1'b0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    gnt      = '0;
    for (int i = N_PE - 1; i >= 0; i--) begin
      hi_idx_s = (req[i] && (i > int'(ptr)))  ? SNOOP_IDX_W'(i) : hi_idx_s;
      lo_idx_s = (req[i] && (i <= int'(ptr))) ? SNOOP_IDX_W'(i) : lo_idx_s;
      hi_hit_s = hi_hit_s | (req[i] && (i > int'(ptr)));
      lo_hit_s = lo_hit_s | (req[i] && (i <= int'(ptr)));
    end
    gnt_valid = hi_hit_s | lo_hit_s;
    gnt_idx   = hi_hit_s ? hi_idx_s : lo_idx_s;
    for (int i = 0; i < N_PE; i++) begin
      gnt[i] = gnt_valid && (int'(gnt_idx) == i);
    end
  end

endmodule

// File: rtl/snoop_request_arbiter.sv
// One-slot-per-PE snoop request buffer with round-robin serialisation into
// the snoop controller. Optional WAIT_RESP timeout: define SNOOP_TIMEOUT_EN.
module snoop_request_arbiter
  import snoop_request_arbiter_pkg::*;
#(
  parameter int N_PE           = 2,
  parameter int BCAST_HOLD     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  snoop_request_arbiter_if.slave bus
);

  localparam int                HOLD_W    = $clog2(BCAST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BCAST_HOLD - 1);

  logic [2:0]               state_r;
  slot_t                    slot_r [N_PE];
  logic [N_PE-1:0]          full_r;
  logic [N_PE-1:0]          gnt_oh_r;
  logic [SNOOP_IDX_W-1:0]   ptr_r;
  logic [HOLD_W-1:0]        hold_cnt_r;
  logic [SNOOP_ADDR_W-1:0]  sc_addr_r;
  logic [SNOOP_BLOCK_W-1:0] sc_data_r;
  logic [SNOOP_IDX_W-1:0]   sc_pe_idx_r;
  logic                     sc_new_data_r;
  logic                     sc_request_r;
  logic [N_PE-1:0]          resp_valid_r;
  logic                     resp_found_r;

  logic [N_PE-1:0]          accept_s;
  logic [N_PE-1:0]          gnt_s;
  logic [SNOOP_IDX_W-1:0]   gnt_idx_s;
  logic                     gnt_valid_s;
  slot_t                    sel_slot_s;
  logic                     cur_type_s;

`ifdef SNOOP_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             timeout_err_r;
  assign bus.timeout_err = timeout_err_r;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // A slot is only writable while empty, which also locks out the granted PE until DONE
  assign accept_s         = bus.pe_req_valid & ~full_r;
  assign bus.pe_req_ready = ~full_r;

  assign bus.sc_addr       = sc_addr_r;
  assign bus.sc_data       = sc_data_r;
  assign bus.sc_pe_idx     = sc_pe_idx_r;
  assign bus.sc_new_data   = sc_new_data_r;
  assign bus.sc_request    = sc_request_r;
  assign bus.pe_resp_valid = resp_valid_r;
  assign bus.pe_resp_found = resp_found_r;

  rr_arbiter #(.N_PE(N_PE)) u_rr (
    .req       (full_r),
    .ptr       (ptr_r),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Slot being granted this cycle, and request type of the transaction in flight
  always_comb begin
    sel_slot_s = '0;
    cur_type_s = 1'b0;
    for (int i = 0; i < N_PE; i++) begin
      sel_slot_s = gnt_s[i] ? slot_r[i] : sel_slot_s;
      cur_type_s = cur_type_s | (gnt_oh_r[i] & slot_r[i].req_type);
    end
  end

  // Per-PE request slots: fill on accept, free at the end of DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= '0;
      for (int i = 0; i < N_PE; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PE; i++) begin
        if (accept_s[i]) begin
          full_r[i]          <= 1'b1;
          slot_r[i].req_type <= bus.pe_req_type[i];
          slot_r[i].addr     <= bus.pe_req_addr[SNOOP_ADDR_W*i +: SNOOP_ADDR_W];
          slot_r[i].data     <= bus.pe_req_data[SNOOP_BLOCK_W*i +: SNOOP_BLOCK_W];
        end else if ((state_r == ST_DONE) && gnt_oh_r[i]) begin
          full_r[i] <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM; strobes and the response pulse default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      gnt_oh_r      <= '0;
      ptr_r         <= SNOOP_IDX_W'(N_PE - 1);
      hold_cnt_r    <= '0;
      sc_addr_r     <= '0;
      sc_data_r     <= '0;
      sc_pe_idx_r   <= '0;
      sc_new_data_r <= 1'b0;
      sc_request_r  <= 1'b0;
      resp_valid_r  <= '0;
      resp_found_r  <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      tmo_cnt_r     <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      sc_new_data_r <= 1'b0;
      sc_request_r  <= 1'b0;
      resp_valid_r  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            gnt_oh_r    <= gnt_s;
            ptr_r       <= gnt_idx_s;
            sc_addr_r   <= sel_slot_s.addr;
            sc_data_r   <= sel_slot_s.data;
            sc_pe_idx_r <= gnt_idx_s;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (is_write(cur_type_s)) begin
            sc_new_data_r <= 1'b1;
          end else begin
            sc_request_r <= 1'b1;
          end
          state_r <= ST_STROBE;
        end
        ST_STROBE: begin
          hold_cnt_r <= '0;
`ifdef SNOOP_TIMEOUT_EN
          tmo_cnt_r  <= '0;
`endif
          state_r    <= is_write(cur_type_s) ? ST_WAIT_BCAST : ST_WAIT_RESP;
        end
        ST_WAIT_BCAST: begin
          if (hold_cnt_r == HOLD_LAST) begin
            resp_valid_r <= gnt_oh_r;
            resp_found_r <= 1'b0;
            state_r      <= ST_DONE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_WAIT_RESP: begin
          // FOUND dominates when the controller raises both replies together
          if (bus.sc_data_found || bus.sc_data_not_found) begin
            resp_valid_r <= gnt_oh_r;
            resp_found_r <= bus.sc_data_found;
            state_r      <= ST_DONE;
          end
`ifdef SNOOP_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            resp_valid_r  <= gnt_oh_r;
            resp_found_r  <= 1'b0;
            timeout_err_r <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
`endif
        end
        ST_DONE: begin
          resp_found_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
